// File: rtl/pwm_multi_ramp.sv
// rtl/pwm_multi_ramp.sv - multi-channel ESC/servo PWM with arm sequence and slew-limited ramp
module pwm_multi_ramp #(
    parameter int NUM_CH     = 3,
    parameter int CNT_W      = 18,
    parameter int PERIOD     = 240000,
    parameter int DEB_DIV    = 3000000,
    parameter int MIN_PULSE  = 12000,
    parameter int MAX_PULSE  = 24000,
    parameter int RAMP_STEP  = 120,
    parameter int ARM_FRAMES = 50
) (
    input  logic                                        i_clk,
    input  logic                                        i_rst_n,
    input  logic                                        i_start,
    input  logic                                        i_wr_en,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] i_wr_ch,
    input  logic [CNT_W-1:0]                            i_wr_duty,
    output logic [NUM_CH-1:0]                           o_pwm,
    output logic [1:0]                                  o_state,
    output logic                                        o_frame_tick,
    output logic                                        o_settled
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DEB_W = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
    localparam int ARM_W = (ARM_FRAMES > 1) ? $clog2(ARM_FRAMES) : 1;

    localparam logic [CNT_W-1:0] LAST_C     = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] MIN_C      = CNT_W'(MIN_PULSE);
    localparam logic [CNT_W-1:0] MAX_C      = CNT_W'(MAX_PULSE);
    localparam logic [CNT_W-1:0] STEP_C     = CNT_W'(RAMP_STEP);
    localparam logic [DEB_W-1:0] DEB_LAST_C = DEB_W'(DEB_DIV - 1);
    localparam logic [ARM_W-1:0] ARM_LAST_C = ARM_W'(ARM_FRAMES - 1);

    // Parameter sanity: reject configurations the counters cannot represent
    if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
        $error("pwm_multi_ramp: NUM_CH must be 1..8");
    end
    if (PERIOD > (1 << CNT_W)) begin : g_bad_period
        $error("pwm_multi_ramp: PERIOD does not fit in CNT_W bits");
    end
    if (MIN_PULSE > MAX_PULSE || MAX_PULSE >= PERIOD) begin : g_bad_pulse
        $error("pwm_multi_ramp: need MIN_PULSE <= MAX_PULSE < PERIOD");
    end
    if (ARM_FRAMES < 1 || DEB_DIV < 1) begin : g_bad_misc
        $error("pwm_multi_ramp: ARM_FRAMES and DEB_DIV must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RAMP = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DEB_W-1:0]  deb_q, deb_d;
    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              samp1_q, samp1_d;
    logic              samp2_q, samp2_d;
    logic              pend_q, pend_d;
    state_t            state_q, state_d;
    logic [ARM_W-1:0]  arm_q, arm_d;
    logic              settled_q, settled_d;
    logic [NUM_CH-1:0] pwm_q, pwm_d;
    logic [CNT_W-1:0]  target_q [NUM_CH];
    logic [CNT_W-1:0]  target_d [NUM_CH];
    logic [CNT_W-1:0]  active_q [NUM_CH];
    logic [CNT_W-1:0]  active_d [NUM_CH];
    logic [CNT_W-1:0]  step_v   [NUM_CH];

    logic tick;
    logic deb_en;
    logic press;
    logic req;
    logic all_eq;
    logic any_diff;

    function automatic logic [CNT_W-1:0] clamp_duty(input logic [CNT_W-1:0] d);
        if (d < MIN_C) begin
            return MIN_C;
        end else if (d > MAX_C) begin
            return MAX_C;
        end
        return d;
    endfunction

    // Move cur toward tgt by at most STEP_C; compare first so the subtraction never wraps
    function automatic logic [CNT_W-1:0] step_toward(input logic [CNT_W-1:0] cur,
                                                     input logic [CNT_W-1:0] tgt);
        logic [CNT_W-1:0] diff;
        if (tgt > cur) begin
            diff = tgt - cur;
            return cur + ((diff > STEP_C) ? STEP_C : diff);
        end
        diff = cur - tgt;
        return cur - ((diff > STEP_C) ? STEP_C : diff);
    endfunction

    assign tick   = (cnt_q == LAST_C);
    assign deb_en = (deb_q == DEB_LAST_C);
    assign press  = samp1_q & ~samp2_q & deb_en;
    assign req    = pend_q | press;

    // Frame counter, button synchroniser/debounce and press latch
    always_comb begin
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        deb_d   = deb_en ? '0 : deb_q + 1'b1;
        sync1_d = i_start;
        sync2_d = sync1_q;
        samp1_d = deb_en ? sync2_q : samp1_q;
        samp2_d = deb_en ? samp1_q : samp2_q;
        pend_d  = tick ? 1'b0 : req;
    end

    // Target duty write port; out-of-range channel indices match nothing
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            target_d[k] = target_q[k];
            if (i_wr_en && (i_wr_ch == CH_W'(k))) begin
                target_d[k] = clamp_duty(i_wr_duty);
            end
        end
    end

    // Candidate per-channel slew step and convergence flags for this boundary
    always_comb begin
        all_eq   = 1'b1;
        any_diff = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            step_v[k] = step_toward(active_q[k], target_q[k]);
            if (step_v[k] != target_q[k]) begin
                all_eq = 1'b0;
            end
            if (active_q[k] != target_q[k]) begin
                any_diff = 1'b1;
            end
        end
    end

    // Sequencer: every state change and duty update happens only on the frame tick
    always_comb begin
        state_d = state_q;
        arm_d   = arm_q;
        for (int k = 0; k < NUM_CH; k++) begin
            active_d[k] = active_q[k];
        end
        if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        state_d = ST_ARM;
                        arm_d   = '0;
                    end
                end
                ST_ARM: begin
                    if (req) begin
                        state_d = ST_IDLE;
                    end else if (arm_q == ARM_LAST_C) begin
                        state_d = ST_RAMP;
                    end else begin
                        arm_d = arm_q + 1'b1;
                    end
                end
                ST_RAMP: begin
                    if (req) begin
                        state_d = ST_IDLE;
                    end else begin
                        for (int k = 0; k < NUM_CH; k++) begin
                            active_d[k] = step_v[k];
                        end
                        if (all_eq) begin
                            state_d = ST_RUN;
                        end
                    end
                end
                default: begin
                    if (req) begin
                        state_d = ST_IDLE;
                    end else if (any_diff) begin
                        state_d = ST_RAMP;
                        for (int k = 0; k < NUM_CH; k++) begin
                            active_d[k] = step_v[k];
                        end
                    end
                end
            endcase
        end
        // Idle and arming always present the arming pulse, so a ramp starts from MIN
        if (state_d == ST_IDLE || state_d == ST_ARM) begin
            for (int k = 0; k < NUM_CH; k++) begin
                active_d[k] = MIN_C;
            end
        end
        settled_d = (state_d == ST_RUN);
    end

    // PWM compare, registered one clock behind the counter
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            pwm_d[k] = (state_q != ST_IDLE) && (cnt_q < active_q[k]);
        end
    end

    // State registers; reset drops the outputs immediately
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q     <= '0;
            deb_q     <= '0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            samp1_q   <= 1'b0;
            samp2_q   <= 1'b0;
            pend_q    <= 1'b0;
            state_q   <= ST_IDLE;
            arm_q     <= '0;
            settled_q <= 1'b0;
            pwm_q     <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                target_q[k] <= MIN_C;
                active_q[k] <= MIN_C;
            end
        end else begin
            cnt_q     <= cnt_d;
            deb_q     <= deb_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            samp1_q   <= samp1_d;
            samp2_q   <= samp2_d;
            pend_q    <= pend_d;
            state_q   <= state_d;
            arm_q     <= arm_d;
            settled_q <= settled_d;
            pwm_q     <= pwm_d;
            for (int k = 0; k < NUM_CH; k++) begin
                target_q[k] <= target_d[k];
                active_q[k] <= active_d[k];
            end
        end
    end

    assign o_pwm        = pwm_q;
    assign o_state      = state_q;
    assign o_frame_tick = tick;
    assign o_settled    = settled_q;

endmodule

// File: tb/tb_pwm_multi_ramp.sv
// tb/tb_pwm_multi_ramp.sv - directed frame-by-frame checks of pwm_multi_ramp
module tb_pwm_multi_ramp;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 18;

    logic              clk;
    logic              i_rst_n;
    logic              i_start;
    logic              i_wr_en;
    logic [1:0]        i_wr_ch;
    logic [CNT_W-1:0]  i_wr_duty;
    logic [NUM_CH-1:0] o_pwm;
    logic [1:0]        o_state;
    logic              o_frame_tick;
    logic              o_settled;

    int n_vec;
    int n_bad;
    int fno;
    int wid [3];
    int fst;
    int fset;

    pwm_multi_ramp #(
        .NUM_CH    (NUM_CH),
        .CNT_W     (CNT_W),
        .PERIOD    (100),
        .DEB_DIV   (4),
        .MIN_PULSE (10),
        .MAX_PULSE (40),
        .RAMP_STEP (7),
        .ARM_FRAMES(2)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_wr_en     (i_wr_en),
        .i_wr_ch     (i_wr_ch),
        .i_wr_duty   (i_wr_duty),
        .o_pwm       (o_pwm),
        .o_state     (o_state),
        .o_frame_tick(o_frame_tick),
        .o_settled   (o_settled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_tick();
        bit got;
        got = 1'b0;
        for (int j = 0; j < 200 && !got; j++) begin
            @(negedge clk);
            if (o_frame_tick) got = 1'b1;
        end
        if (!got) chk("tick_timeout", 0, 1);
    endtask

    // Count cycles from now to the next tick, checking outputs stay idle
    task automatic count_to_tick(output int n);
        bit got;
        int busy;
        got  = 1'b0;
        busy = 0;
        n    = -1;
        for (int j = 1; j < 200 && !got; j++) begin
            @(negedge clk);
            if (o_pwm != '0 || o_state != 2'd0) busy++;
            if (o_frame_tick) begin
                got = 1'b1;
                n   = j;
            end
        end
        chk("post_reset_idle", busy, 0);
    endtask

    task automatic do_write(input int ch, input int duty);
        @(negedge clk);
        i_wr_en   = 1'b1;
        i_wr_ch   = 2'(ch);
        i_wr_duty = CNT_W'(duty);
        @(negedge clk);
        i_wr_en   = 1'b0;
    endtask

    // Measure one full frame starting right after a tick sample; optional button and write
    task automatic meas_frame(input int btn_at, input int btn_len,
                              input int wr_at, input int wch, input int wduty);
        int acc [3];
        bit got;
        got = 1'b0;
        for (int k = 0; k < 3; k++) acc[k] = 0;
        for (int j = 0; j < 200 && !got; j++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) acc[k] += int'(o_pwm[k]);
            if (o_frame_tick) begin
                got  = 1'b1;
                fst  = int'(o_state);
                fset = int'(o_settled);
            end
            i_start = (j >= btn_at) && (j < btn_at + btn_len);
            if (j == wr_at) begin
                i_wr_en   = 1'b1;
                i_wr_ch   = 2'(wch);
                i_wr_duty = CNT_W'(wduty);
            end else begin
                i_wr_en = 1'b0;
            end
        end
        i_start = 1'b0;
        i_wr_en = 1'b0;
        if (!got) chk("frame_timeout", 0, 1);
        for (int k = 0; k < 3; k++) wid[k] = acc[k];
    endtask

    task automatic check_frame(input int st, input int w0, input int w1, input int w2,
                               input int set, input int btn_at, input int btn_len,
                               input int wr_at, input int wch, input int wduty);
        meas_frame(btn_at, btn_len, wr_at, wch, wduty);
        fno++;
        chk($sformatf("f%0d_state", fno), fst, st);
        chk($sformatf("f%0d_w0", fno), wid[0], w0);
        chk($sformatf("f%0d_w1", fno), wid[1], w1);
        chk($sformatf("f%0d_w2", fno), wid[2], w2);
        chk($sformatf("f%0d_settled", fno), fset, set);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        int nt;
        int pw;
        int sn;
        int last;
        int badint;
        int n;

        n_vec     = 0;
        n_bad     = 0;
        fno       = 0;
        i_rst_n   = 1'b0;
        i_start   = 1'b0;
        i_wr_en   = 1'b0;
        i_wr_ch   = '0;
        i_wr_duty = '0;

        repeat (3) @(negedge clk);
        chk("rst_pwm", int'(o_pwm), 0);
        chk("rst_state", int'(o_state), 0);
        chk("rst_tick", int'(o_frame_tick), 0);
        chk("rst_settled", int'(o_settled), 0);
        i_rst_n = 1'b1;

        // Idle for 500 clocks: no pulses, ticks every 100 clocks at counter 99
        first = -1; nt = 0; pw = 0; sn = 0; last = -1; badint = 0;
        for (int i = 1; i <= 500; i++) begin
            @(negedge clk);
            if (o_pwm != '0) pw++;
            if (o_state != 2'd0) sn++;
            if (o_frame_tick) begin
                nt++;
                if (first < 0) first = i;
                else if (i - last != 100) badint++;
                last = i;
            end
        end
        chk("idle_first_tick", first, 99);
        chk("idle_tick_count", nt, 5);
        chk("idle_tick_spacing", badint, 0);
        chk("idle_pwm", pw, 0);
        chk("idle_state", sn, 0);

        // Targets written while idle: clamp to 10, 31, 40
        do_write(1, 31);
        do_write(0, 5);
        do_write(2, 99);
        wait_tick();

        // Button held 20 clocks, then arm for 2 frames, then ramp
        check_frame(0,  0,  0,  0, 0,  0, 20, -1, 0, 0);
        check_frame(1, 10, 10, 10, 0, -1,  0, -1, 0, 0);
        check_frame(1, 10, 10, 10, 0, -1,  0, -1, 0, 0);
        check_frame(2, 10, 10, 10, 0, -1,  0, -1, 0, 0);
        check_frame(2, 10, 17, 17, 0, -1,  0, -1, 0, 0);
        check_frame(2, 10, 24, 24, 0, -1,  0, -1, 0, 0);
        check_frame(2, 10, 31, 31, 0, -1,  0, -1, 0, 0);
        check_frame(2, 10, 31, 38, 0, -1,  0, -1, 0, 0);
        check_frame(3, 10, 31, 40, 1, -1,  0, -1, 0, 0);

        // In RUN, retarget ch1 to 12 mid-frame; ramps down at boundaries only
        check_frame(3, 10, 31, 40, 1, -1,  0, 30, 1, 12);
        check_frame(2, 10, 24, 40, 0, -1,  0, -1, 0, 0);
        check_frame(2, 10, 17, 40, 0, -1,  0, -1, 0, 0);
        check_frame(3, 10, 12, 40, 1, -1,  0, -1, 0, 0);

        // Press at counter 50: frame completes, then idle
        check_frame(3, 10, 12, 40, 1, 50, 20, -1, 0, 0);
        check_frame(0,  0,  0,  0, 0, -1,  0, -1, 0, 0);

        // Second press restarts arming at MIN_PULSE
        check_frame(0,  0,  0,  0, 0,  0, 20, -1, 0, 0);
        check_frame(1, 10, 10, 10, 0, -1,  0, -1, 0, 0);
        check_frame(1, 10, 10, 10, 0, -1,  0, -1, 0, 0);
        check_frame(2, 10, 10, 10, 0, -1,  0, -1, 0, 0);
        check_frame(2, 10, 12, 17, 0, -1,  0, -1, 0, 0);

        // Reset at counter 5 during RAMP (active 10, 12, 24)
        repeat (6) @(negedge clk);
        chk("pre_rst_pwm", int'(o_pwm), 7);
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_pwm", int'(o_pwm), 0);
        chk("mid_rst_state", int'(o_state), 0);
        repeat (3) @(negedge clk);
        i_rst_n = 1'b1;
        count_to_tick(n);
        chk("post_rst_first_tick", n, 99);

        // Targets back to 10: a single ramp frame settles straight into RUN
        check_frame(0,  0,  0,  0, 0,  0, 20, -1, 0, 0);
        check_frame(1, 10, 10, 10, 0, -1,  0, -1, 0, 0);
        check_frame(1, 10, 10, 10, 0, -1,  0, -1, 0, 0);
        check_frame(2, 10, 10, 10, 0, -1,  0, -1, 0, 0);

        // Write to channel 3 is out of range and must change nothing
        check_frame(3, 10, 10, 10, 1, -1,  0, 20, 3, 40);
        check_frame(3, 10, 10, 10, 1, -1,  0, -1, 0, 0);
        check_frame(3, 10, 10, 10, 1, -1,  0, -1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
